// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BE_W           = DATA_W / 8;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned DMEM_DEPTH_DEF = 1024;
    localparam int unsigned DMEM_WAIT_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

    // Replace only the enabled byte lanes of old_word with new_word.
    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word RAM: synchronous write, combinational read, never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEF,
    parameter int unsigned IDX_W       = $clog2(DMEM_DEPTH_DEF)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= be_merge(mem[wr_idx], wr_data, wr_be);
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: latches one request, waits WAIT_CYCLES,
// then acknowledges for one cycle; stores commit on the edge leaving RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              acc_err;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        acc_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    req_d = '{we: we, addr: addr, wdata: wdata, be: be};
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response is evaluated on the edge entering RESP, from the latched request.
        acc_err = (req_d.addr[1:0] != 2'b00) || (req_d.addr[31:2] >= 30'(DEPTH_WORDS));
        if ((state_d == RESP) && (state_q != RESP)) begin
            ack_d   = 1'b1;
            err_d   = acc_err;
            rdata_d = (!acc_err && !req_d.we) ? mem_rdata : '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // A reset during RESP aborts the pending store.
    assign mem_wr_en = (state_q == RESP) && req_q.we && !err_q && !reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clock  (clock),
        .wr_en  (mem_wr_en),
        .wr_idx (req_q.addr[IDX_W+1:2]),
        .wr_data(req_q.wdata),
        .wr_be  (req_q.be),
        .rd_idx (req_d.addr[IDX_W+1:2]),
        .rd_data(mem_rdata)
    );

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset, req, req0, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata, rdata0;
    logic        ack, err, busy, ack0, err0, busy0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .req(req0), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] m;
        m = model.exists(int'(a >> 2)) ? model[int'(a >> 2)] : 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
        model[int'(a >> 2)] = m;
    endtask

    // One complete access on the WAIT_CYCLES=2 instance, inputs scrambled after acceptance.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input string tag);
        int          lat;
        logic        e;
        logic [31:0] expd;
        e    = exp_err(a);
        expd = (e || w) ? 32'h0 : model[int'(a >> 2)];
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        tick;
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
        lat = 1;
        while (ack !== 1'b1 && lat < 20) begin
            chk({tag, " wait outs"}, 32'({busy, err, (rdata !== 32'h0)}), 32'b100);
            tick;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd3);
        chk({tag, " err"}, 32'(err), 32'(e));
        chk({tag, " rdata"}, rdata, expd);
        tick;
        chk({tag, " idle"}, 32'({ack, err, busy}), 32'h0);
        if (w && !e) model_store(a, d, b);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old, a;
        int          r, idx;

        // Reset with a store request pending: must be ignored.
        reset = 1'b1; req = 1'b1; req0 = 1'b1; we = 1'b1; addr = 32'h0; wdata = $urandom; be = 4'hF;
        tick;
        tick;
        chk("reset ack/err/busy", 32'({ack, err, busy}), 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset dut0 outs", 32'({ack0, err0, busy0, (rdata0 !== 32'h0)}), 32'h0);
        req = 1'b0; req0 = 1'b0; reset = 1'b0;
        tick;
        chk("post-reset idle", 32'({ack, busy}), 32'h0);

        // Give every word the bench will touch a known value.
        for (int i = 0; i < 16; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF, "init");
        access(1'b1, 32'hFFC, $urandom, 4'hF, "init top");

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st 0x10");
        access(1'b0, 32'h10, 32'h0, 4'h0, "ld 0x10");
        chk("ld 0x10 value", model[4], 32'hDEADBEEF);
        access(1'b1, 32'h10, 32'h000000AA, 4'b0001, "partial st");
        access(1'b0, 32'h10, 32'h0, 4'h0, "ld partial");
        access(1'b1, 32'h10, 32'h12345678, 4'b0000, "st be0");
        access(1'b0, 32'h10, 32'h0, 4'h0, "ld after be0");

        access(1'b0, 32'h13, 32'h0, 4'h0, "ld misaligned");
        access(1'b1, 32'h1000, $urandom, 4'hF, "st out of range");
        access(1'b0, 32'h0, 32'h0, 4'h0, "ld word0");
        access(1'b0, 32'hFFC, 32'h0, 4'h0, "ld word1023");

        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 9);
            idx = (r == 9) ? 1023 : int'($urandom_range(0, 15));
            a   = 32'(idx * 4);
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = 32'($urandom_range(1024, 4095) * 4);
            access(1'($urandom), a, $urandom, 4'($urandom), "rand");
        end

        // Three back-to-back stores with req held high.
        req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hA0A0A0A0; be = 4'hF;
        tick;
        for (int c = 1; c <= 12; c++) begin
            chk("b2b ack", 32'(ack), 32'((c % 4) == 3));
            chk("b2b busy", 32'(busy), 32'((c % 4) != 0));
            if (c == 4) begin addr = 32'h4; wdata = 32'hB1B1B1B1; end
            if (c == 8) begin addr = 32'h8; wdata = 32'hC2C2C2C2; end
            if (c == 11) req = 1'b0;
            tick;
        end
        model_store(32'h0, 32'hA0A0A0A0, 4'hF);
        model_store(32'h4, 32'hB1B1B1B1, 4'hF);
        model_store(32'h8, 32'hC2C2C2C2, 4'hF);
        access(1'b0, 32'h0, 32'h0, 4'h0, "b2b ld0");
        access(1'b0, 32'h4, 32'h0, 4'h0, "b2b ld1");
        access(1'b0, 32'h8, 32'h0, 4'h0, "b2b ld2");

        // Reset during WAIT of a store.
        old = model[8];
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = ~old; be = 4'hF;
        tick;
        req = 1'b0;
        chk("abort wait busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick;
        chk("abort wait outs", 32'({ack, busy}), 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("abort wait no ack", 32'(ack), 32'h0);
        end
        access(1'b0, 32'h20, 32'h0, 4'h0, "ld after wait abort");

        // Reset during RESP of a store.
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = ~old; be = 4'hF;
        tick;
        req = 1'b0;
        tick;
        tick;
        chk("abort resp ack", 32'(ack), 32'h1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort resp outs", 32'({ack, busy}), 32'h0);
        access(1'b0, 32'h20, 32'h0, 4'h0, "ld after resp abort");

        // Zero-wait instance: store then load with the address toggled after acceptance.
        req0 = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h5EED5EED; be = 4'hF;
        tick;
        req0 = 1'b0;
        chk("w0 st ack", 32'({ack0, err0}), 32'b10);
        tick;
        chk("w0 st idle", 32'({ack0, busy0}), 32'h0);
        req0 = 1'b1; we = 1'b0; addr = 32'h40;
        tick;
        req0 = 1'b0; addr = 32'h44; we = 1'b1;
        chk("w0 ld ack", 32'({ack0, err0}), 32'b10);
        chk("w0 ld rdata", rdata0, 32'h5EED5EED);
        tick;
        chk("w0 ld idle", 32'({ack0, busy0, (rdata0 !== 32'h0)}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of storage (power of two).
REQ-002 The block SHALL take parameter WAIT_CYCLES, default 2, meaning the number of wait states between request acceptance and response (0..15).
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit, asserted by the CPU to request an access.
REQ-006 The block SHALL have port we, input, 1 bit, where 1 means store and 0 means load.
REQ-007 The block SHALL have port addr, input, 32 bits, the byte address.
REQ-008 The block SHALL have port wdata, input, 32 bits, the store data.
REQ-009 The block SHALL have port be, input, 4 bits, the store byte enables, where bit i covers wdata[8i+7:8i].
REQ-010 The block SHALL have port rdata, output, 32 bits, the load data, valid only while ack is high.
REQ-011 The block SHALL have port ack, output, 1 bit, a one-cycle response strobe.
REQ-012 The block SHALL have port err, output, 1 bit, an error flag that is qualified by ack.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL latch we, addr, wdata and be at that edge; later changes on the inputs SHALL be ignored until the next acceptance.
REQ-016 The accepting edge SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1; if WAIT_CYCLES=0, it SHALL go directly to RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-018 Latency SHALL be exactly WAIT_CYCLES+1 cycles from the accepting edge to ack high; ack SHALL be high for exactly the one cycle spent in RESP.
REQ-019 RESP SHALL always go to IDLE, so the earliest next acceptance is the cycle after ack; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-020 The access SHALL be flagged as an error when latched addr[1:0]!=0 or the word index addr[31:2]>=DEPTH_WORDS.
REQ-021 On error, the block SHALL drive ack=1, err=1 and rdata=0 in RESP, and SHALL NOT modify memory.
REQ-022 For a legal load, rdata SHALL equal mem[addr[31:2]] in RESP, with err=0.
REQ-023 For a legal store, the write SHALL be committed only on the edge leaving RESP, per enabled byte; rdata SHALL be 0 during a store ack.
REQ-024 A store with be=4'b0000 SHALL be acknowledged with err=0 and SHALL leave memory unchanged.
REQ-025 A load following a store to the same word SHALL return the newly written data.
REQ-026 Outside RESP, ack, err and rdata SHALL be 0.

Reset
REQ-027 While reset is high, the FSM SHALL be in IDLE, the counter SHALL be 0, ack=err=busy=0, rdata=0, and the latched request registers SHALL be 0.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the access with no memory write and no ack; a req present during reset SHALL be ignored.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 A shared package dmem_pkg SHALL hold the state enumeration (IDLE, WAIT, RESP) and the default values of DEPTH_WORDS and WAIT_CYCLES.
REQ-031 Storage SHALL be a sub-module dmem_array: a synchronous-write, byte-enabled word RAM with a combinational read port; the FSM, counter and error check SHALL reside in dmem_responder.

Verification
REQ-032 Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10 -> each ack arrives 3 cycles after acceptance (WAIT_CYCLES=2), and the load returns rdata=0xDEADBEEF with err=0.
REQ-033 Partial store addr=0x10, wdata=0x000000AA, be=4'b0001 over 0xDEADBEEF, then load -> rdata=0xDEADBEAA.
REQ-034 Load addr=0x13 (misaligned), then store addr=0x1000 (DEPTH_WORDS=1024) -> both respond with ack=1, err=1, rdata=0, and a subsequent load of word 0 and word 1023 shows them unchanged.
REQ-035 Hold req=1 continuously for 3 stores -> acks at cycles 3, 7 and 11 after the first acceptance; busy=0 only on the cycle following each ack.
REQ-036 Assert reset during WAIT of a store to 0x20 -> no ack is produced and a later load of 0x20 returns the prior value.
REQ-037 With WAIT_CYCLES=0, a load -> ack arrives on the cycle after acceptance; toggling addr after acceptance does not change the returned rdata.
